// File: rtl/serial_add_initiator.sv
// Host-side initiator for a serial adder engine: accepts one operand pair at a time,
// pulses the engine, captures its result (or a timeout) into a 2-entry result FIFO.
module serial_add_initiator #(
   parameter int TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_sum,
   output logic       res_err,
   output logic [7:0] eng_a,
   output logic [7:0] eng_b,
   output logic       eng_start,
   input  logic [7:0] eng_c,
   input  logic       eng_done,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, WAIT_CLR} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] tmo_cnt;

   // FIFO entry layout: {sum[7:0], err}
   logic [8:0] fifo_mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push;
   logic       pop;
   logic [8:0] push_data;

   assign op_ready  = (state == IDLE) && (count < 2'd2) && !rst;
   assign res_valid = (count != 2'd0);
   assign pop       = res_valid && res_ready;

   // Head is masked when empty so stale entries never show on res_sum/res_err.
   always_comb begin
      if (res_valid) begin
         res_sum = fifo_mem[rd_ptr][8:1];
         res_err = fifo_mem[rd_ptr][0];
      end else begin
         res_sum = 8'h00;
         res_err = 1'b0;
      end
   end

   // A result is pushed on engine completion or when the wait budget runs out.
   always_comb begin
      push      = 1'b0;
      push_data = 9'h000;
      if (state == WAIT_DONE) begin
         if (eng_done) begin
            push      = 1'b1;
            push_data = {eng_c, 1'b0};
         end else if (tmo_cnt == TMO_LAST) begin
            push      = 1'b1;
            push_data = {8'h00, 1'b1};
         end else begin
            push      = 1'b0;
            push_data = 9'h000;
         end
      end else begin
         push      = 1'b0;
         push_data = 9'h000;
      end
   end

   // Operation sequencer with registered engine controls and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tmo_cnt   <= 8'd0;
         eng_a     <= 8'h00;
         eng_b     <= 8'h00;
         eng_start <= 1'b0;
         busy      <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid && op_ready) begin
                  eng_a     <= op_a;
                  eng_b     <= op_b;
                  eng_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               tmo_cnt <= 8'd0;
               state   <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (push) begin
                  state <= WAIT_CLR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            // Hold here until done drops so a long done pulse is captured once.
            WAIT_CLR: begin
               if (!eng_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Result FIFO; push never sees a full FIFO because accepts require count<2.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_mem[0] <= 9'h000;
         fifo_mem[1] <= 9'h000;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/serial_add_initiator.md
SERIAL_ADD_INITIATOR -- requirements
Module: serial_add_initiator

Interface
REQ-001 Parameter: TIMEOUT, 31, max cycles spent in WAIT_DONE before timeout (range 12..255).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op_valid  input  1  host offers operand pair.
REQ-005 op_ready  output  1  block accepts operand pair this cycle.
REQ-006 op_a, op_b  input  8 each  operands.
REQ-007 res_valid  output  1  result FIFO head valid.
REQ-008 res_ready  input  1  host consumes FIFO head.
REQ-009 res_sum  output  8  FIFO head sum.
REQ-010 res_err  output  1  FIFO head timeout flag.
REQ-011 eng_a, eng_b  output  8 each  operands driven to the serial adder engine.
REQ-012 eng_start  output  1  engine start pulse.
REQ-013 eng_c  input  8  engine result.
REQ-014 eng_done  input  1  engine completion; may stay high for several cycles.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 The block SHALL be a 4-state FSM: IDLE, START, WAIT_DONE, WAIT_CLR, plus a 2-entry result FIFO {sum[7:0], err}.
REQ-017 op_ready SHALL equal (state==IDLE) && (fifo_count<2) && !rst; it is combinational.
REQ-018 On op_valid&&op_ready at an edge: eng_a<=op_a, eng_b<=op_b, state<=START.
REQ-019 eng_a/eng_b SHALL hold stable from acceptance until the FSM returns to IDLE.
REQ-020 In START, eng_start SHALL be 1 for exactly one cycle; next state WAIT_DONE; timeout counter cleared to 0.
REQ-021 eng_start SHALL be 0 in every other state.
REQ-022 In WAIT_DONE with eng_done=1: push {eng_c, 0} into FIFO; state<=WAIT_CLR.
REQ-023 In WAIT_DONE with eng_done=0: counter increments; when counter reaches TIMEOUT-1, push {8'h00, 1}, state<=WAIT_CLR.
REQ-024 In WAIT_CLR: remain until eng_done=0, then state<=IDLE; a done pulse is therefore captured exactly once.
REQ-025 Minimum accept-to-accept spacing SHALL be 4 cycles (accept, START, WAIT_DONE, WAIT_CLR) plus engine latency.
REQ-026 FIFO: res_valid=(count>0); res_sum/res_err show head; pop on res_valid&&res_ready.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 Overflow SHALL be impossible by construction (accept only when count<2, one operation in flight); pop on empty SHALL be ignored.
REQ-029 Results SHALL appear in operand acceptance order; sum is (a+b) mod 256 as returned by the engine, unmodified.
REQ-030 eng_done asserted while in IDLE or START SHALL be ignored.

Reset
REQ-031 While rst=1 at an edge: state<=IDLE, FIFO emptied (count=0), counter<=0, eng_a=eng_b=8'h00.
REQ-032 Output values during and after reset: eng_start=0, res_valid=0, res_sum=8'h00, res_err=0, busy=0, op_ready=0 while rst=1.
REQ-033 Reset mid-operation SHALL drop the in-flight operation without pushing a result; the engine SHALL share the same rst.
REQ-034 The first operand pair SHALL be accepted no earlier than the first edge with rst=0.

Verification (behavioural engine model: done after 10 cycles, held 2 cycles, c=(a+b) mod 256)
REQ-035 Single op: a=0x35, b=0x4A -> one eng_start pulse, eng_a/eng_b stable, res_sum=0x7F, res_err=0, busy falls after done drops.
REQ-036 Wrap: a=0xFF, b=0x02 -> res_sum=0x01, res_err=0.
REQ-037 Back-pressure: res_ready=0, issue 3 ops (0x01+0x01, 0x10+0x20, 0x80+0x80) -> results 0x02, 0x30 queued; op_ready stays 0 for the third until one pop; then results 0x02, 0x30, 0x00 in order.
REQ-038 Timeout: engine model never asserts done, TIMEOUT=31 -> after 31 WAIT_DONE cycles, res_sum=0x00, res_err=1, FSM back in IDLE next cycle.
REQ-039 Held done: eng_done held high 5 cycles -> exactly one FIFO push, FSM leaves WAIT_CLR the cycle after done falls.
REQ-040 Reset mid-op: rst asserted during WAIT_DONE -> eng_start=0, res_valid=0, no result pushed; next op 0x05+0x06 -> res_sum=0x0B.
